dmem_arbiter: RTL and testbench

- Arbitrates the single-port data memory between the pipeline MEM stage (CPU port) and a DMA/debug loader port.
- Sits between the memory-access stage and data_memory, driving that memory's WE/A/WD and receiving its combinational RD.
- The CPU owns the memory by default. DMA gets idle cycles, bounded bursts and a starvation override.
- Asserts cpu_stall so the hazard unit can freeze the PC, IF/ID, ID/EX and EX/MEM registers.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_arb_fsm.sv | 56 +++++
 rtl/dmem_arbiter.sv | 100 ++++++++++
 tb/tb_dmem_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding and default sizing.
package dmem_pkg;

  localparam int DMEM_ADDR_W     = 32;
  localparam int DMEM_DATA_W     = 32;
  localparam int DMEM_STARVE_MAX = 4;
  localparam int DMEM_MAX_BURST  = 8;

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dmem_arb_fsm.sv
// Ownership FSM for the data memory: decides each cycle whether the CPU or the DMA port
// gets the memory, with a starvation override for DMA and a burst cap against the CPU.
module dmem_arb_fsm
  import dmem_pkg::*;
#(
  parameter int STARVE_MAX = DMEM_STARVE_MAX,
  parameter int MAX_BURST  = DMEM_MAX_BURST
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic dma_req,
  input  logic dma_last,
  output logic grant_dma,
  output logic grant_cpu
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [7:0] BURST_LIM  = 8'(MAX_BURST);

  arb_state_t state, state_nxt;
  logic [3:0] starve_cnt;
  logic [7:0] burst_cnt;

  always_comb begin
    grant_dma = 1'b0;
    if (dma_req) begin
      if (state == S_DMA) grant_dma = !cpu_req || (burst_cnt < BURST_LIM);
      else                grant_dma = !cpu_req || (starve_cnt == STARVE_LIM);
    end
    grant_cpu = cpu_req && !grant_dma;
    state_nxt = (grant_dma && !dma_last) ? S_DMA : S_CPU;
  end

  // The burst count only matters while DMA holds the memory against a waiting CPU.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_CPU;
      starve_cnt <= '0;
      burst_cnt  <= '0;
    end else begin
      state <= state_nxt;

      if (grant_dma || !dma_req)
        starve_cnt <= '0;
      else if (grant_cpu && starve_cnt != STARVE_LIM)
        starve_cnt <= starve_cnt + 4'd1;

      if (state_nxt == S_CPU || !cpu_req)
        burst_cnt <= '0;
      else if (grant_dma && burst_cnt != 8'hFF)
        burst_cnt <= burst_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the MEM stage and a DMA/debug loader port.
// Define DMEM_ARB_PERF_EN to build the stall / DMA-grant performance counters.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int STARVE_MAX = DMEM_STARVE_MAX,
  parameter int MAX_BURST  = DMEM_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_last,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_dma_cnt
);

  logic grant_dma, grant_cpu;

  dmem_arb_fsm #(
    .STARVE_MAX(STARVE_MAX),
    .MAX_BURST (MAX_BURST)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .dma_req  (dma_req),
    .dma_last (dma_last),
    .grant_dma(grant_dma),
    .grant_cpu(grant_cpu)
  );

  assign dma_gnt   = grant_dma;
  assign cpu_stall = cpu_req && !grant_cpu;
  assign cpu_rdata = mem_rdata;

  // A write must never reach memory while reset is asserted, even mid-burst.
  always_comb begin
    if (grant_dma) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we && grant_cpu;
    end
    if (rst) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else if (grant_dma && !dma_we) begin
      dma_rvalid <= 1'b1;
      dma_rdata  <= mem_rdata;
    end else begin
      dma_rvalid <= 1'b0;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] stall_cnt_q, dma_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      dma_cnt_q   <= '0;
    end else begin
      if (cpu_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (grant_dma) dma_cnt_q   <= dma_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_dma_cnt   = dma_cnt_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_dma_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table plus randomized traffic
// checked against a cycle-level reference model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int STARVE_MAX = dmem_pkg::DMEM_STARVE_MAX;
  localparam int MAX_BURST  = dmem_pkg::DMEM_MAX_BURST;

  typedef struct {
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        dma_req;
    logic        dma_we;
    logic        dma_last;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [31:0] mem_rdata;
    logic        chk;
    logic        exp_gnt;
    logic        exp_stall;
    logic        exp_we;
    logic        exp_rvalid;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_last;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic        cpu_stall, dma_gnt, dma_rvalid, mem_we;
  logic [31:0] perf_stall_cnt, perf_dma_cnt;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model: who owns the memory, and how long each side has been waiting / holding.
  bit          m_dma_owns;
  int          m_cpu_wins_while_dma_waits;
  int          m_dma_beats_while_cpu_waits;
  bit          m_rvalid;
  logic [31:0] m_rdata;
  logic [31:0] m_pstall, m_pdma;
  bit          m_gdma;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_last(dma_last), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .perf_stall_cnt(perf_stall_cnt), .perf_dma_cnt(perf_dma_cnt)
  );

  function automatic vec_t mk(input logic r, input logic creq, input logic cwe,
                              input logic [31:0] caddr, input logic dreq, input logic dwe,
                              input logic dlast, input logic [31:0] daddr,
                              input logic [31:0] rd, input logic g, input logic s,
                              input logic w, input logic rv);
    vec_t v;
    v.rst = r; v.cpu_req = creq; v.cpu_we = cwe; v.cpu_addr = caddr;
    v.cpu_wdata = caddr ^ 32'hA5A5_0000;
    v.dma_req = dreq; v.dma_we = dwe; v.dma_last = dlast; v.dma_addr = daddr;
    v.dma_wdata = daddr ^ 32'h5A5A_0000;
    v.mem_rdata = rd; v.chk = 1'b1;
    v.exp_gnt = g; v.exp_stall = s; v.exp_we = w; v.exp_rvalid = rv;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst; cpu_req = v.cpu_req; cpu_we = v.cpu_we; cpu_addr = v.cpu_addr;
    cpu_wdata = v.cpu_wdata; dma_req = v.dma_req; dma_we = v.dma_we; dma_last = v.dma_last;
    dma_addr = v.dma_addr; dma_wdata = v.dma_wdata; mem_rdata = v.mem_rdata;
  endtask

  // Compare all outputs mid-cycle against the model and, for table rows, the hand-derived values.
  task automatic checkOutput(input vec_t v);
    logic        e_stall, e_we;
    logic [31:0] e_addr, e_wdata;
    if (v.dma_req) begin
      if (m_dma_owns) m_gdma = !v.cpu_req || (m_dma_beats_while_cpu_waits < MAX_BURST);
      else            m_gdma = !v.cpu_req || (m_cpu_wins_while_dma_waits >= STARVE_MAX);
    end else begin
      m_gdma = 1'b0;
    end
    e_stall = v.cpu_req && m_gdma;
    e_addr  = m_gdma ? v.dma_addr  : v.cpu_addr;
    e_wdata = m_gdma ? v.dma_wdata : v.cpu_wdata;
    e_we    = v.rst ? 1'b0 : (m_gdma ? v.dma_we : (v.cpu_req && v.cpu_we));
    if (!v.rst) begin
      check("dma_gnt",   {31'd0, dma_gnt},   {31'd0, m_gdma});
      check("cpu_stall", {31'd0, cpu_stall}, {31'd0, e_stall});
      check("mem_addr",  mem_addr,  e_addr);
      check("mem_wdata", mem_wdata, e_wdata);
    end
    check("mem_we",     {31'd0, mem_we},     {31'd0, e_we});
    check("cpu_rdata",  cpu_rdata,  v.mem_rdata);
    check("dma_rvalid", {31'd0, dma_rvalid}, {31'd0, m_rvalid});
    check("dma_rdata",  dma_rdata,  m_rdata);
    check("perf_stall", perf_stall_cnt, m_pstall);
    check("perf_dma",   perf_dma_cnt,   m_pdma);
    if (v.chk) begin
      if (!v.rst) begin
        check("tbl_gnt",   {31'd0, dma_gnt},   {31'd0, v.exp_gnt});
        check("tbl_stall", {31'd0, cpu_stall}, {31'd0, v.exp_stall});
      end
      check("tbl_we",     {31'd0, mem_we},     {31'd0, v.exp_we});
      check("tbl_rvalid", {31'd0, dma_rvalid}, {31'd0, v.exp_rvalid});
    end
  endtask

  task automatic modelEdge(input vec_t v);
    if (v.rst) begin
      m_dma_owns = 1'b0; m_cpu_wins_while_dma_waits = 0; m_dma_beats_while_cpu_waits = 0;
      m_rvalid = 1'b0; m_rdata = '0; m_pstall = '0; m_pdma = '0;
      return;
    end
`ifdef DMEM_ARB_PERF_EN
    if (v.cpu_req && m_gdma) m_pstall = m_pstall + 32'd1;
    if (m_gdma) m_pdma = m_pdma + 32'd1;
`endif
    m_rvalid = m_gdma && !v.dma_we;
    if (m_rvalid) m_rdata = v.mem_rdata;
    if (m_gdma || !v.dma_req) m_cpu_wins_while_dma_waits = 0;
    else if (v.cpu_req)
      m_cpu_wins_while_dma_waits = (m_cpu_wins_while_dma_waits + 1 > STARVE_MAX) ?
                                   STARVE_MAX : m_cpu_wins_while_dma_waits + 1;
    m_dma_owns = m_gdma && !v.dma_last;
    if (!m_dma_owns || !v.cpu_req) m_dma_beats_while_cpu_waits = 0;
    else if (m_dma_beats_while_cpu_waits < 255) m_dma_beats_while_cpu_waits++;
  endtask

  task automatic runCycle(input vec_t v);
    applyStimulus(v);
    #3;
    checkOutput(v);
    @(posedge clk);
    modelEdge(v);
    #1;
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;

    m_gdma = 1'b0;
    v = mk(1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
    v.chk = 1'b0;
    applyStimulus(v);
    @(posedge clk); @(posedge clk);
    modelEdge(v);
    #1;
    check("rst_rvalid", {31'd0, dma_rvalid}, 32'd0);
    check("rst_rdata",  dma_rdata, 32'd0);
    check("rst_pstall", perf_stall_cnt, 32'd0);
    check("rst_pdma",   perf_dma_cnt, 32'd0);

    // CPU load, then an uncontested 3-beat DMA write burst.
    tbl.push_back(mk(0, 1, 0, 32'h10, 0, 0, 0, 32'h0,  32'hDEADBEEF, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h14, 1, 1, 0, 32'h40, 32'h0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h14, 1, 1, 0, 32'h44, 32'h0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 32'h14, 1, 1, 1, 32'h48, 32'h0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 32'h20, 0, 0, 0, 32'h0,  32'h0, 0, 0, 1, 0));
    // Contention with single-beat DMA reads: four CPU wins, one forced DMA grant, repeated.
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, 0, 32'h24, 1, 0, 1, 32'h80, 32'h12345678, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h24, 1, 0, 1, 32'h80, 32'h12345678, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h24, 1, 0, 1, 32'h80, 32'h0, 0, 0, 0, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 0, 32'h24, 1, 0, 1, 32'h80, 32'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h24, 1, 0, 1, 32'h84, 32'hCAFEF00D, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h28, 0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 1));
    // Long DMA write burst: CPU arrives on beat 2, waits out MAX_BURST beats, then starvation resumes DMA.
    tbl.push_back(mk(0, 0, 0, 32'h28, 1, 1, 0, 32'h100, 32'h0, 1, 0, 1, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 1, 0, 32'h2C, 1, 1, 0, 32'h104 + 32'(4 * i), 32'h0, 1, 1, 1, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, 0, 32'h2C, 1, 1, 0, 32'h124, 32'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h2C, 1, 1, 0, 32'h124, 32'h0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 32'h2C, 1, 1, 0, 32'h128, 32'h0, 1, 1, 1, 0));
    // Reset mid-burst: no write in the reset cycle, CPU owns the memory right after.
    tbl.push_back(mk(1, 1, 0, 32'h2C, 1, 1, 0, 32'h12C, 32'h0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h30, 1, 1, 0, 32'h130, 32'h0, 0, 0, 1, 0));

    $display("[TB] directed table: %0d rows", tbl.size());
    foreach (tbl[i]) runCycle(tbl[i]);

    // Randomized traffic with occasional resets, checked against the model only.
    for (int n = 0; n < 3000; n++) begin
      v.rst       = ($urandom_range(0, 99) == 0);
      v.cpu_req   = ($urandom_range(0, 99) < 65);
      v.cpu_we    = 1'($urandom);
      v.cpu_addr  = $urandom;
      v.cpu_wdata = $urandom;
      v.dma_req   = ($urandom_range(0, 99) < 60);
      v.dma_we    = 1'($urandom);
      v.dma_last  = ($urandom_range(0, 11) == 0);
      v.dma_addr  = $urandom;
      v.dma_wdata = $urandom;
      v.mem_rdata = $urandom;
      v.chk = 1'b0; v.exp_gnt = 1'b0; v.exp_stall = 1'b0; v.exp_we = 1'b0; v.exp_rvalid = 1'b0;
      runCycle(v);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
